// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot/run sequencing, fetch handshake, execute redirects,
// misaligned-target trapping and a saturating redirect counter.
module pc_gen #(
   parameter int unsigned             CPU_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0]    RESET_PC  = '0,
   parameter logic [CPU_WIDTH-1:0]    TRAP_PC   = CPU_WIDTH'(32'h100),
   parameter int unsigned             CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 branch_i,
   input  logic                 taken_i,
   input  logic                 jump_i,
   input  logic                 jalr_i,
   input  logic [CPU_WIDTH-1:0] ex_pc_i,
   input  logic [CPU_WIDTH-1:0] imm_i,
   input  logic [CPU_WIDTH-1:0] rs1_i,
   input  logic                 fetch_ready_i,
   output logic                 fetch_valid_o,
   output logic [CPU_WIDTH-1:0] fetch_pc_o,
   output logic                 flush_o,
   output logic                 misalign_o,
   output logic [CPU_WIDTH-1:0] misalign_addr_o,
   output logic [CNT_WIDTH-1:0] redir_cnt_o
);

   typedef enum logic [0:0] {StBoot, StRun} state_e;

   state_e                 state_q, state_d;
   logic [CPU_WIDTH-1:0]   pc_q, pc_d;
   logic                   flush_q, flush_d;
   logic                   misalign_q, misalign_d;
   logic [CPU_WIDTH-1:0]   mis_addr_q, mis_addr_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic                   redir;
   logic [CPU_WIDTH-1:0]   jalr_sum;
   logic [CPU_WIDTH-1:0]   target;
   logic                   target_bad;

   assign redir    = jalr_i | jump_i | (branch_i & taken_i);
   assign jalr_sum = rs1_i + imm_i;

   // jalr outranks jal/branch; jal and branch share the PC-relative adder.
   always_comb begin
      target = ex_pc_i + imm_i;
      if (jalr_i) begin
         target = {jalr_sum[CPU_WIDTH-1:1], 1'b0};
      end
   end

   assign target_bad = target[1];

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      flush_d    = 1'b0;
      misalign_d = 1'b0;
      mis_addr_d = mis_addr_q;
      cnt_d      = cnt_q;

      unique case (state_q)
         StBoot: begin
            state_d = StRun;
         end
         StRun: begin
            if (redir) begin
               flush_d = 1'b1;
               if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
               if (target_bad) begin
                  pc_d       = TRAP_PC;
                  misalign_d = 1'b1;
                  mis_addr_d = target;
               end else begin
                  pc_d = target;
               end
            end else if (stall_i) begin
               pc_d = pc_q;
            end else if (fetch_ready_i) begin
               pc_d = pc_q + CPU_WIDTH'(4);
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StBoot;
         pc_q       <= RESET_PC;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
         mis_addr_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
         mis_addr_q <= mis_addr_d;
         cnt_q      <= cnt_d;
      end
   end

   assign fetch_valid_o   = (state_q == StRun) & ~stall_i;
   assign fetch_pc_o      = pc_q;
   assign flush_o         = flush_q;
   assign misalign_o      = misalign_q;
   assign misalign_addr_o = mis_addr_q;
   assign redir_cnt_o     = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver updates a reference model and queues expected outputs,
// a monitor pops one entry per cycle and compares.
module tb_pc_gen;

   localparam int unsigned W   = 32;
   localparam int unsigned CW  = 2;
   localparam logic [W-1:0] RPC = 32'h80;
   localparam logic [W-1:0] TPC = 32'h100;

   logic          clk = 1'b0;
   logic          rst, stall, branch, taken, jump, jalr, ready;
   logic [W-1:0]  ex_pc, imm, rs1;
   logic          fvalid, flush, mis;
   logic [W-1:0]  fpc, mis_addr;
   logic [CW-1:0] cnt;

   always #5 clk = ~clk;

   pc_gen #(
      .CPU_WIDTH (W),
      .RESET_PC  (RPC),
      .TRAP_PC   (TPC),
      .CNT_WIDTH (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall),
      .branch_i        (branch),
      .taken_i         (taken),
      .jump_i          (jump),
      .jalr_i          (jalr),
      .ex_pc_i         (ex_pc),
      .imm_i           (imm),
      .rs1_i           (rs1),
      .fetch_ready_i   (ready),
      .fetch_valid_o   (fvalid),
      .fetch_pc_o      (fpc),
      .flush_o         (flush),
      .misalign_o      (mis),
      .misalign_addr_o (mis_addr),
      .redir_cnt_o     (cnt)
   );

   typedef struct {
      logic         valid;
      logic [W-1:0] pc;
      logic         flush;
      logic         mis;
      logic [W-1:0] maddr;
      int unsigned  cnt;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state: "running" means the first post-reset edge has passed.
   bit           m_run   = 0;
   logic [W-1:0] m_pc    = RPC;
   logic [W-1:0] m_maddr = '0;
   int unsigned  m_cnt   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Apply inputs before the next rising edge and predict the state that edge produces.
   task automatic step(input logic r, input logic st, input logic br, input logic tk,
                       input logic jp, input logic jr, input logic [W-1:0] ep,
                       input logic [W-1:0] im, input logic [W-1:0] r1, input logic rd);
      exp_t         e;
      bit           take;
      longint unsigned sum;
      logic [W-1:0] tgt;
      rst = r; stall = st; branch = br; taken = tk; jump = jp; jalr = jr;
      ex_pc = ep; imm = im; rs1 = r1; ready = rd;
      e.flush = 0;
      e.mis   = 0;
      if (r) begin
         m_run = 0; m_pc = RPC; m_maddr = '0; m_cnt = 0;
      end else if (!m_run) begin
         m_run = 1;
      end else begin
         take = jr || jp || (br && tk);
         if (jr) begin
            sum = (longint'(r1) + longint'(im)) % 64'h1_0000_0000;
            sum = sum - (sum % 2);
         end else begin
            sum = (longint'(ep) + longint'(im)) % 64'h1_0000_0000;
         end
         tgt = sum[W-1:0];
         if (take) begin
            e.flush = 1;
            m_cnt   = (m_cnt == 3) ? 3 : m_cnt + 1;
            if ((sum / 2) % 2 == 1) begin
               e.mis   = 1;
               m_maddr = tgt;
               m_pc    = TPC;
            end else begin
               m_pc = tgt;
            end
         end else if (!st && rd) begin
            sum  = (longint'(m_pc) + 4) % 64'h1_0000_0000;
            m_pc = sum[W-1:0];
         end
      end
      e.valid = m_run && !st;
      e.pc    = m_pc;
      e.maddr = m_maddr;
      e.cnt   = m_cnt;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input logic st, input logic rd);
      step(1'b0, st, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, rd);
   endtask

   // Monitor: one expected entry is consumed per rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("fetch_valid", {31'b0, fvalid}, {31'b0, e.valid});
            chk("fetch_pc", fpc, e.pc);
            chk("flush", {31'b0, flush}, {31'b0, e.flush});
            chk("misalign", {31'b0, mis}, {31'b0, e.mis});
            chk("misalign_addr", mis_addr, e.maddr);
            chk("redir_cnt", {30'b0, cnt}, e.cnt[W-1:0]);
         end
      end
   end

   initial begin
      logic [W-1:0] rv;
      step(1, 0, 0, 0, 0, 0, '0, '0, '0, 1);
      step(1, 0, 0, 0, 0, 0, '0, '0, '0, 1);
      repeat (4) idle(0, 1);
      // jal to 0x90, then hold with ready low, advance, stall
      step(0, 0, 0, 0, 1, 0, 32'h80, 32'h10, '0, 0);
      repeat (3) idle(0, 0);
      idle(0, 1);
      repeat (2) idle(1, 1);
      // taken branch under stall, then not-taken branch
      step(0, 1, 1, 1, 0, 0, 32'h100, 32'hFFFF_FFF0, '0, 1);
      step(0, 0, 1, 0, 0, 0, 32'h100, 32'h40, '0, 1);
      // jalr clears bit0; jalr to bit1-set target traps
      step(0, 0, 0, 0, 0, 1, '0, 32'h1, 32'h203, 1);
      step(0, 0, 0, 0, 0, 1, '0, 32'h0, 32'h202, 1);
      idle(0, 1);
      // jal and taken branch together: jal wins; back-to-back redirects
      step(0, 0, 1, 1, 1, 0, 32'h400, 32'h20, '0, 1);
      step(0, 0, 1, 1, 0, 0, 32'h400, 32'h80, '0, 1);
      // wrap at top of address space
      step(0, 0, 0, 0, 0, 1, '0, 32'h0, 32'hFFFF_FFFC, 1);
      repeat (2) idle(0, 1);
      // mid-stream reset
      step(1, 0, 0, 0, 1, 0, 32'h0, 32'h8, '0, 1);
      repeat (2) idle(0, 1);
      repeat (400) begin
         rv = $urandom;
         step(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 5) == 0), rv[0], ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) == 0), $urandom & 32'hFFFF_FFFC,
              ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
              $urandom, ($urandom_range(0, 3) != 0));
      end
      repeat (5) begin
         if (q.size() != 0) @(negedge clk);
      end
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
